// File: rtl/adc_channel_scheduler.sv
// -----------------------------------------------------------------------------
// adc_channel_scheduler
//
// Shares one non-pipelined ADC correction engine among NUM_CH ADC channels.
// Each channel has a one-deep holding buffer. A round-robin arbiter picks a
// pending channel and presents its sample to the engine with a one-cycle start
// pulse. It then holds the sample stable until the engine answers, and returns
// the corrected value tagged with the channel number. A watchdog aborts jobs
// whose engine never answers.
//
// Ports:
//   sys_clk_i      system clock, rising edge
//   reset_i        asynchronous active-low reset
//   enable_i       allows new grants when high
//   ch_data_i      channel samples, channel k at [k*DATA_W +: DATA_W]
//   ch_valid_i     one-cycle per-channel "new sample" strobe
//   eng_data_o     sample presented to the engine (held for the whole job)
//   eng_srdyi_o    one-cycle engine start pulse
//   eng_result_i   engine result
//   eng_srdyo_i    engine result-ready strobe
//   corr_data_o    corrected sample
//   corr_ch_o      channel tag of corr_data_o
//   corr_valid_o   one-cycle strobe for corr_data_o / corr_ch_o
//   busy_o         high while the FSM is not in IDLE
//   overrun_o      sticky per-channel overrun flags
//   timeout_err_o  sticky engine-timeout flag
//   err_clr_i      clears overrun_o and timeout_err_o
// -----------------------------------------------------------------------------
module adc_channel_scheduler #(
    parameter int NUM_CH  = 32,
    parameter int DATA_W  = 21,
    parameter int CH_W    = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic                     sys_clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    output logic [DATA_W-1:0]        eng_data_o,
    output logic                     eng_srdyi_o,
    input  logic [DATA_W-1:0]        eng_result_i,
    input  logic                     eng_srdyo_i,
    output logic [DATA_W-1:0]        corr_data_o,
    output logic [CH_W-1:0]          corr_ch_o,
    output logic                     corr_valid_o,
    output logic                     busy_o,
    output logic [NUM_CH-1:0]        overrun_o,
    output logic                     timeout_err_o,
    input  logic                     err_clr_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0]   samp_buf_q [NUM_CH];
    logic [DATA_W-1:0]   samp_buf_d [NUM_CH];
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [CH_W-1:0]     ch_tag_q, ch_tag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   eng_data_q, eng_data_d;
    logic                eng_srdyi_q, eng_srdyi_d;
    logic [DATA_W-1:0]   corr_data_q, corr_data_d;
    logic [CH_W-1:0]     corr_ch_q, corr_ch_d;
    logic                corr_valid_q, corr_valid_d;
    logic                busy_q, busy_d;
    logic [NUM_CH-1:0]   overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;

    logic [CH_W-1:0]     winner_s;
    logic                grant_s;
    logic [NUM_CH-1:0]   grant_oh_s;
    logic [NUM_CH-1:0]   overrun_set_s;
    logic                timeout_set_s;

    // Round-robin winner: first pending channel searching upward from last_grant+1.
    always_comb begin : arb_comb
        int              idx;
        logic [CH_W-1:0] sel;
        idx      = 0;
        sel      = '0;
        winner_s = '0;
        // Walk offsets from farthest to nearest so the nearest pending one ends up selected.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx      = (int'(last_grant_q) + i) % NUM_CH;
            sel      = CH_W'(idx);
            winner_s = pend_q[sel] ? sel : winner_s;
        end
        grant_s    = (state_q == ST_IDLE) && enable_i && (|pend_q);
        grant_oh_s = grant_s ? ({{(NUM_CH-1){1'b0}}, 1'b1} << winner_s) : {NUM_CH{1'b0}};
    end

    // Capture of channel strobes into the holding buffers and overrun detection.
    always_comb begin : cap_comb
        // A strobe wins over the grant's clear, so a sample arriving in the grant cycle stays pending.
        pend_d        = ch_valid_i | (pend_q & ~grant_oh_s);
        overrun_set_s = ch_valid_i & pend_q & ~grant_oh_s;
        overrun_d     = overrun_set_s | (err_clr_i ? {NUM_CH{1'b0}} : overrun_q);
        for (int k = 0; k < NUM_CH; k++) begin
            samp_buf_d[k] = ch_valid_i[k] ? ch_data_i[k*DATA_W +: DATA_W] : samp_buf_q[k];
        end
    end

    // Job FSM next-state and output-register next values.
    always_comb begin : fsm_comb
        state_d       = state_q;
        cnt_d         = cnt_q;
        eng_data_d    = eng_data_q;
        ch_tag_d      = ch_tag_q;
        last_grant_d  = last_grant_q;
        eng_srdyi_d   = 1'b0;
        corr_data_d   = corr_data_q;
        corr_ch_d     = corr_ch_q;
        corr_valid_d  = 1'b0;
        timeout_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    eng_data_d   = samp_buf_q[winner_s];
                    ch_tag_d     = winner_s;
                    last_grant_d = winner_s;
                    eng_srdyi_d  = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (eng_srdyo_i) begin
                    corr_data_d = eng_result_i;
                    corr_ch_d   = ch_tag_q;
                    state_d     = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle: drop the job silently.
                    timeout_set_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                // corr_valid_o is registered, so it is seen the cycle after DONE.
                corr_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        timeout_err_d = timeout_set_s | (err_clr_i ? 1'b0 : timeout_err_q);
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards pending samples and any job in flight.
    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            pend_q        <= {NUM_CH{1'b0}};
            last_grant_q  <= CH_W'(NUM_CH - 1);
            ch_tag_q      <= {CH_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            eng_data_q    <= {DATA_W{1'b0}};
            eng_srdyi_q   <= 1'b0;
            corr_data_q   <= {DATA_W{1'b0}};
            corr_ch_q     <= {CH_W{1'b0}};
            corr_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= {NUM_CH{1'b0}};
            timeout_err_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                samp_buf_q[k] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            last_grant_q  <= last_grant_d;
            ch_tag_q      <= ch_tag_d;
            cnt_q         <= cnt_d;
            eng_data_q    <= eng_data_d;
            eng_srdyi_q   <= eng_srdyi_d;
            corr_data_q   <= corr_data_d;
            corr_ch_q     <= corr_ch_d;
            corr_valid_q  <= corr_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            for (int k = 0; k < NUM_CH; k++) begin
                samp_buf_q[k] <= samp_buf_d[k];
            end
        end
    end

    assign eng_data_o    = eng_data_q;
    assign eng_srdyi_o   = eng_srdyi_q;
    assign corr_data_o   = corr_data_q;
    assign corr_ch_o     = corr_ch_q;
    assign corr_valid_o  = corr_valid_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_channel_scheduler
//
// Directed bench for adc_channel_scheduler. A small engine model answers each
// start pulse with data+1 after a configurable latency (or never, for a chosen
// number of jobs) and logs issues and corrected outputs with cycle numbers.
// -----------------------------------------------------------------------------
module tb_adc_channel_scheduler;

    localparam int NUM_CH = 32;
    localparam int DATA_W = 21;
    localparam int CH_W   = 5;

    logic                     sys_clk_i = 1'b0;
    logic                     reset_i;
    logic                     enable_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_i;
    logic [NUM_CH-1:0]        ch_valid_i;
    logic [DATA_W-1:0]        eng_data_o;
    logic                     eng_srdyi_o;
    logic [DATA_W-1:0]        eng_result_i;
    logic                     eng_srdyo_i;
    logic [DATA_W-1:0]        corr_data_o;
    logic [CH_W-1:0]          corr_ch_o;
    logic                     corr_valid_o;
    logic                     busy_o;
    logic [NUM_CH-1:0]        overrun_o;
    logic                     timeout_err_o;
    logic                     err_clr_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // engine model state and logs
    int                eng_cnt     = 0;
    int                eng_lat_cfg = 40;
    int                hang_jobs   = 0;
    int                hold_viol   = 0;
    logic [DATA_W-1:0] eng_lat     = '0;
    logic [DATA_W-1:0] iss_data_q[$];
    int                iss_cyc_q[$];
    int                srdyo_cyc_q[$];
    logic [CH_W-1:0]   corr_ch_q[$];
    logic [DATA_W-1:0] corr_data_q[$];
    int                corr_cyc_q[$];

    adc_channel_scheduler dut (
        .sys_clk_i    (sys_clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .ch_data_i    (ch_data_i),
        .ch_valid_i   (ch_valid_i),
        .eng_data_o   (eng_data_o),
        .eng_srdyi_o  (eng_srdyi_o),
        .eng_result_i (eng_result_i),
        .eng_srdyo_i  (eng_srdyo_i),
        .corr_data_o  (corr_data_o),
        .corr_ch_o    (corr_ch_o),
        .corr_valid_o (corr_valid_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .timeout_err_o(timeout_err_o),
        .err_clr_i    (err_clr_i)
    );

    initial forever #5 sys_clk_i = ~sys_clk_i;

    initial forever begin
        @(posedge sys_clk_i);
        cyc++;
    end

    // Engine model and output logger, evaluated mid-cycle.
    initial begin
        eng_srdyo_i  = 1'b0;
        eng_result_i = '0;
        forever begin
            @(negedge sys_clk_i);
            eng_srdyo_i = 1'b0;
            if (eng_cnt != 0) begin
                if (eng_data_o !== eng_lat) hold_viol++;
                if (eng_cnt == 1) begin
                    eng_srdyo_i  = 1'b1;
                    eng_result_i = eng_lat + 21'd1;
                    srdyo_cyc_q.push_back(cyc);
                end
                eng_cnt--;
            end
            if (eng_srdyi_o === 1'b1) begin
                iss_data_q.push_back(eng_data_o);
                iss_cyc_q.push_back(cyc);
                if (hang_jobs > 0) begin
                    hang_jobs--;
                end else begin
                    eng_cnt = eng_lat_cfg;
                    eng_lat = eng_data_o;
                end
            end
            if (corr_valid_o === 1'b1) begin
                corr_ch_q.push_back(corr_ch_o);
                corr_data_q.push_back(corr_data_o);
                corr_cyc_q.push_back(cyc);
            end
        end
    end

    function automatic logic [NUM_CH*DATA_W-1:0] mk(input int ch, input logic [DATA_W-1:0] v);
        logic [NUM_CH*DATA_W-1:0] r;
        r = '0;
        r[ch*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    task automatic clear_logs();
        iss_data_q.delete();
        iss_cyc_q.delete();
        srdyo_cyc_q.delete();
        corr_ch_q.delete();
        corr_data_q.delete();
        corr_cyc_q.delete();
        hold_viol = 0;
    endtask

    // Drive one-cycle strobes starting at the current negedge; returns one negedge later.
    task automatic strobe(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] data,
                          input logic clr);
        ch_valid_i = mask;
        ch_data_i  = data;
        err_clr_i  = clr;
        @(negedge sys_clk_i);
        ch_valid_i = '0;
        ch_data_i  = '0;
        err_clr_i  = 1'b0;
    endtask

    task automatic wait_corr(input int n, input int bound);
        for (int i = 0; i < bound && corr_ch_q.size() < n; i++) @(negedge sys_clk_i);
        repeat (3) @(negedge sys_clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b0; enable_i = 1'b1; ch_valid_i = '0; ch_data_i = '0; err_clr_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        checks++; if (eng_srdyi_o !== 1'b0) begin errors++; $display("FAIL reset_srdyi got %0h exp 0", eng_srdyi_o); end
        checks++; if (eng_data_o !== 21'd0) begin errors++; $display("FAIL reset_eng_data got %0h exp 0", eng_data_o); end
        checks++; if ({corr_valid_o, busy_o, timeout_err_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %0b exp 000", {corr_valid_o, busy_o, timeout_err_o}); end
        checks++; if ({corr_data_o, corr_ch_o} !== 26'd0) begin errors++; $display("FAIL reset_corr got %0h exp 0", {corr_data_o, corr_ch_o}); end
        checks++; if (overrun_o !== 32'd0) begin errors++; $display("FAIL reset_overrun got %0h exp 0", overrun_o); end
        reset_i = 1'b1;
        clear_logs();
        repeat (5) @(negedge sys_clk_i);
        checks++; if (iss_cyc_q.size() != 0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_no_grant got issues=%0d busy=%0b exp 0 0", iss_cyc_q.size(), busy_o); end
    endtask

    task automatic test_fairness();
        logic [NUM_CH*DATA_W-1:0] d;
        clear_logs();
        eng_lat_cfg = 8;
        d = '0;
        for (int k = 0; k < NUM_CH; k++) d[k*DATA_W +: DATA_W] = 21'h01000 + DATA_W'(k);
        strobe('1, d, 1'b0);
        wait_corr(32, 2000);
        checks++; if (corr_ch_q.size() != 32) begin errors++; $display("FAIL fair_count got %0d exp 32", corr_ch_q.size()); end
        for (int k = 0; k < NUM_CH && k < corr_ch_q.size(); k++) begin
            checks++; if (corr_ch_q[k] !== CH_W'(k)) begin errors++; $display("FAIL fair_tag[%0d] got %0d exp %0d", k, corr_ch_q[k], k); end
            checks++; if (corr_data_q[k] !== 21'h01001 + DATA_W'(k)) begin errors++; $display("FAIL fair_data[%0d] got %0h exp %0h", k, corr_data_q[k], 21'h01001 + DATA_W'(k)); end
        end
        checks++; if (overrun_o !== 32'd0) begin errors++; $display("FAIL fair_overrun got %0h exp 0", overrun_o); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL fair_hold got %0d exp 0", hold_viol); end
    endtask

    task automatic test_single();
        int t0;
        clear_logs();
        eng_lat_cfg = 40;
        t0 = cyc;
        strobe(32'h8, mk(3, 21'h0ABCD), 1'b0);
        wait_corr(1, 200);
        checks++; if (iss_cyc_q.size() != 1) begin errors++; $display("FAIL single_issues got %0d exp 1", iss_cyc_q.size()); end
        checks++; if (iss_cyc_q[0] != t0 + 2) begin errors++; $display("FAIL single_srdyi_cyc got %0d exp %0d", iss_cyc_q[0], t0 + 2); end
        checks++; if (iss_data_q[0] !== 21'h0ABCD) begin errors++; $display("FAIL single_eng_data got %0h exp 0abcd", iss_data_q[0]); end
        checks++; if (corr_ch_q.size() != 1) begin errors++; $display("FAIL single_corr_count got %0d exp 1", corr_ch_q.size()); end
        checks++; if (corr_cyc_q[0] != srdyo_cyc_q[0] + 2) begin errors++; $display("FAIL single_corr_lat got %0d exp %0d", corr_cyc_q[0], srdyo_cyc_q[0] + 2); end
        checks++; if (corr_cyc_q[0] != t0 + 44) begin errors++; $display("FAIL single_total_lat got %0d exp %0d", corr_cyc_q[0], t0 + 44); end
        checks++; if (corr_ch_q[0] !== 5'd3) begin errors++; $display("FAIL single_tag got %0d exp 3", corr_ch_q[0]); end
        checks++; if (corr_data_q[0] !== 21'h0ABCE) begin errors++; $display("FAIL single_data got %0h exp 0abce", corr_data_q[0]); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL single_hold got %0d exp 0", hold_viol); end
        checks++; if (corr_data_o !== 21'h0ABCE) begin errors++; $display("FAIL single_data_hold got %0h exp 0abce", corr_data_o); end
    endtask

    task automatic test_overrun();
        clear_logs();
        eng_lat_cfg = 10;
        enable_i = 1'b0;
        strobe(32'h20, mk(5, 21'h00011), 1'b0);
        checks++; if (overrun_o !== 32'd0) begin errors++; $display("FAIL ovr_first got %0h exp 0", overrun_o); end
        strobe(32'h20, mk(5, 21'h00022), 1'b0);
        checks++; if (overrun_o !== 32'h20) begin errors++; $display("FAIL ovr_set got %0h exp 20", overrun_o); end
        enable_i = 1'b1;
        wait_corr(1, 100);
        checks++; if (iss_data_q.size() != 1 || iss_data_q[0] !== 21'h00022) begin errors++; $display("FAIL ovr_eng_data got n=%0d d=%0h exp 1 22", iss_data_q.size(), iss_data_q[0]); end
        checks++; if (corr_ch_q[0] !== 5'd5 || corr_data_q[0] !== 21'h00023) begin errors++; $display("FAIL ovr_corr got %0d/%0h exp 5/23", corr_ch_q[0], corr_data_q[0]); end
        checks++; if (overrun_o !== 32'h20) begin errors++; $display("FAIL ovr_sticky got %0h exp 20", overrun_o); end
        strobe('0, '0, 1'b1);
        checks++; if (overrun_o !== 32'd0) begin errors++; $display("FAIL ovr_clear got %0h exp 0", overrun_o); end
        // overrun event coinciding with err_clr: the event wins
        clear_logs();
        enable_i = 1'b0;
        strobe(32'h20, mk(5, 21'h00044), 1'b0);
        strobe(32'h20, mk(5, 21'h00055), 1'b1);
        checks++; if (overrun_o !== 32'h20) begin errors++; $display("FAIL ovr_clr_race got %0h exp 20", overrun_o); end
        enable_i = 1'b1;
        wait_corr(1, 100);
        checks++; if (iss_data_q.size() != 1 || iss_data_q[0] !== 21'h00055) begin errors++; $display("FAIL ovr2_eng_data got n=%0d d=%0h exp 1 55", iss_data_q.size(), iss_data_q[0]); end
        strobe('0, '0, 1'b1);
        checks++; if (overrun_o !== 32'd0) begin errors++; $display("FAIL ovr_clear2 got %0h exp 0", overrun_o); end
    endtask

    task automatic test_set_clear_same_cycle();
        clear_logs();
        enable_i = 1'b0;
        strobe(32'h40, mk(6, 21'h00066), 1'b0);
        enable_i = 1'b1;
        strobe(32'h40, mk(6, 21'h00077), 1'b0);
        wait_corr(2, 200);
        checks++; if (overrun_o !== 32'd0) begin errors++; $display("FAIL sc_overrun got %0h exp 0", overrun_o); end
        checks++; if (iss_data_q.size() != 2) begin errors++; $display("FAIL sc_issues got %0d exp 2", iss_data_q.size()); end
        checks++; if (iss_data_q[0] !== 21'h00066 || iss_data_q[1] !== 21'h00077) begin errors++; $display("FAIL sc_order got %0h,%0h exp 66,77", iss_data_q[0], iss_data_q[1]); end
        checks++; if (corr_ch_q[1] !== 5'd6 || corr_data_q[1] !== 21'h00078) begin errors++; $display("FAIL sc_corr got %0d/%0h exp 6/78", corr_ch_q[1], corr_data_q[1]); end
    endtask

    task automatic test_enable();
        clear_logs();
        enable_i = 1'b0;
        strobe(32'h280, mk(7, 21'h00700) | mk(9, 21'h00900), 1'b0);
        repeat (10) @(negedge sys_clk_i);
        checks++; if (iss_cyc_q.size() != 0 || busy_o !== 1'b0) begin errors++; $display("FAIL en_hold got issues=%0d busy=%0b exp 0 0", iss_cyc_q.size(), busy_o); end
        enable_i = 1'b1;
        wait_corr(2, 200);
        checks++; if (corr_ch_q.size() != 2) begin errors++; $display("FAIL en_count got %0d exp 2", corr_ch_q.size()); end
        checks++; if (corr_ch_q[0] !== 5'd7 || corr_ch_q[1] !== 5'd9) begin errors++; $display("FAIL en_order got %0d,%0d exp 7,9", corr_ch_q[0], corr_ch_q[1]); end
        checks++; if (corr_data_q[0] !== 21'h00701 || corr_data_q[1] !== 21'h00901) begin errors++; $display("FAIL en_data got %0h,%0h exp 701,901", corr_data_q[0], corr_data_q[1]); end
    endtask

    task automatic test_timeout();
        int c;
        clear_logs();
        eng_lat_cfg = 10;
        hang_jobs = 1;
        strobe(32'h1400, mk(10, 21'h000A0) | mk(12, 21'h000C0), 1'b0);
        for (int i = 0; i < 20 && iss_cyc_q.size() < 1; i++) @(negedge sys_clk_i);
        @(negedge sys_clk_i);
        c = iss_cyc_q[0];
        while (cyc < c + 1023) @(negedge sys_clk_i);
        checks++; if (timeout_err_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL to_early got err=%0b busy=%0b exp 0 1", timeout_err_o, busy_o); end
        @(negedge sys_clk_i);
        checks++; if (timeout_err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL to_fire got err=%0b busy=%0b exp 1 0", timeout_err_o, busy_o); end
        wait_corr(1, 100);
        checks++; if (iss_cyc_q.size() != 2 || iss_cyc_q[1] != c + 1025) begin errors++; $display("FAIL to_next_issue got n=%0d cyc=%0d exp 2 %0d", iss_cyc_q.size(), iss_cyc_q[1], c + 1025); end
        checks++; if (iss_data_q[1] !== 21'h000C0) begin errors++; $display("FAIL to_next_data got %0h exp c0", iss_data_q[1]); end
        checks++; if (corr_ch_q.size() != 1 || corr_ch_q[0] !== 5'd12 || corr_data_q[0] !== 21'h000C1) begin errors++; $display("FAIL to_corr got n=%0d %0d/%0h exp 1 12/c1", corr_ch_q.size(), corr_ch_q[0], corr_data_q[0]); end
        strobe('0, '0, 1'b1);
        checks++; if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL to_clear got %0b exp 0", timeout_err_o); end
    endtask

    task automatic test_midjob_reset();
        clear_logs();
        eng_lat_cfg = 40;
        strobe(32'h300000, mk(20, 21'h00200) | mk(21, 21'h00210), 1'b0);
        for (int i = 0; i < 20 && iss_cyc_q.size() < 1; i++) @(negedge sys_clk_i);
        repeat (5) @(negedge sys_clk_i);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mr_busy got %0b exp 1", busy_o); end
        reset_i = 1'b0;
        #1;
        checks++; if ({eng_srdyi_o, corr_valid_o, busy_o, timeout_err_o} !== 4'b0000) begin errors++; $display("FAIL mr_flags got %0b exp 0000", {eng_srdyi_o, corr_valid_o, busy_o, timeout_err_o}); end
        checks++; if ({eng_data_o, corr_data_o, corr_ch_o} !== 47'd0) begin errors++; $display("FAIL mr_data got %0h exp 0", {eng_data_o, corr_data_o, corr_ch_o}); end
        repeat (2) @(negedge sys_clk_i);
        reset_i = 1'b1;
        repeat (60) @(negedge sys_clk_i);
        checks++; if (corr_ch_q.size() != 0) begin errors++; $display("FAIL mr_no_corr got %0d exp 0", corr_ch_q.size()); end
        checks++; if (iss_cyc_q.size() != 1) begin errors++; $display("FAIL mr_pend_cleared got issues=%0d exp 1", iss_cyc_q.size()); end
    endtask

    initial begin
        reset_i = 1'b0; enable_i = 1'b1; ch_valid_i = '0; ch_data_i = '0; err_clr_i = 1'b0;
        @(negedge sys_clk_i);
        test_reset();
        test_fairness();
        test_single();
        test_overrun();
        test_set_clear_same_cycle();
        test_enable();
        test_timeout();
        test_midjob_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
